mc_datapath: RTL

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath_pkg.sv | 53 +++++
 rtl/mc_reg_file.sv | 36 +++
 rtl/mc_datapath.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_pkg.sv
// Shared types for the multi-cycle datapath: decoded control bundle,
// FSM state encoding, ALU operation codes and ImmSrc/ResultSrc selects.
package mc_datapath_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_e;

    // Codes 10-15 are not named; the ALU passes SrcB through for them.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Short immediate is IR[XLEN-1-RW:4], long immediate is IR[XLEN-1:4].
    typedef enum logic [1:0] {
        IMM_SEXT_S = 2'd0,
        IMM_ZEXT_S = 2'd1,
        IMM_SEXT_L = 2'd2,
        IMM_ZEXT_L = 2'd3
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_PC1 = 2'd1,
        RES_MDR = 2'd2,
        RES_IMM = 2'd3
    } result_src_e;

    typedef struct packed {
        result_src_e ResultSrc;
        logic        PcSrc;
        logic        RegWrite;
        imm_src_e    ImmSrc;
        logic        L;
        alu_op_e     ALUControl;
        logic        MemRead;
        logic        MemWrite;
    } ctrl_t;

endpackage

// File: rtl/mc_reg_file.sv
// General-purpose register file: NREG x XLEN, two asynchronous read ports,
// one synchronous write port. Reset clears every entry.
module mc_reg_file #(
    parameter int XLEN = 19,
    parameter int NREG = 16,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [RW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];

    // Reads see the pre-edge contents, so a same-edge write is not forwarded.
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    // Single write port, cleared as a whole on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: FETCH -> DECODE -> EXECUTE -> (MEM) -> WB.
// Optional build macro MC_DATAPATH_PERF_EN adds free-running cycle and
// retired-instruction counters (cycle_cnt, retire_cnt).
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int XLEN = 19,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  ctrl_t           ctrl,
    output logic [XLEN-1:0] IR,
    output logic [XLEN-1:0] PC,
    output logic            Zero,
    output logic            instr_req,
    output logic [XLEN-1:0] instr_addr,
    input  logic [XLEN-1:0] instr_rdata,
    input  logic            instr_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            instr_done
`ifdef MC_DATAPATH_PERF_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     retire_cnt
`endif
);

    localparam int RW    = $clog2(NREG);
    localparam int SHW   = $clog2(XLEN);
    localparam int IMS_W = XLEN - RW - 4;
    localparam int IML_W = XLEN - 4;

    state_e          state;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mdr;

    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic            rf_we;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] pc_plus1;
    logic [XLEN-1:0] wb_result;

    // Shift amounts at or beyond XLEN saturate to XLEN; result wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] alu_calc(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW:0] sh;
        sh = ({1'b0, b[SHW-1:0]} >= (SHW+1)'(XLEN)) ? (SHW+1)'(XLEN) : {1'b0, b[SHW-1:0]};
        case (op)
            ALU_ADD:  alu_calc = a + b;
            ALU_SUB:  alu_calc = a - b;
            ALU_AND:  alu_calc = a & b;
            ALU_OR:   alu_calc = a | b;
            ALU_XOR:  alu_calc = a ^ b;
            ALU_SLL:  alu_calc = a << sh;
            ALU_SRL:  alu_calc = a >> sh;
            ALU_SRA:  alu_calc = $signed(a) >>> sh;
            ALU_SLT:  alu_calc = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_calc = {{(XLEN-1){1'b0}}, (a < b)};
            default:  alu_calc = b;
        endcase
    endfunction

    assign rd  = IR[XLEN-1 -: RW];
    assign rs2 = IR[XLEN-1-RW -: RW];
    assign rs1 = IR[4 +: RW];

    assign instr_addr = PC;
    assign mem_addr   = {{(XLEN-IMS_W){IR[XLEN-1-RW]}}, IR[XLEN-1-RW:4]};
    assign mem_wdata  = b_reg;
    assign pc_plus1   = PC + {{(XLEN-1){1'b0}}, 1'b1};
    assign src_b      = ctrl.L ? imm_ext : b_reg;
    assign alu_res    = alu_calc(ctrl.ALUControl, a_reg, src_b);
    assign rf_we      = (state == S_WB) && ctrl.RegWrite;

    // Immediate extension from the instruction register.
    always_comb begin
        imm_ext = '0;
        case (ctrl.ImmSrc)
            IMM_SEXT_S: imm_ext = {{(XLEN-IMS_W){IR[XLEN-1-RW]}}, IR[XLEN-1-RW:4]};
            IMM_ZEXT_S: imm_ext = {{(XLEN-IMS_W){1'b0}}, IR[XLEN-1-RW:4]};
            IMM_SEXT_L: imm_ext = {{(XLEN-IML_W){IR[XLEN-1]}}, IR[XLEN-1:4]};
            IMM_ZEXT_L: imm_ext = {{(XLEN-IML_W){1'b0}}, IR[XLEN-1:4]};
            default:    imm_ext = '0;
        endcase
    end

    // Write-back result selection.
    always_comb begin
        wb_result = alu_out;
        case (ctrl.ResultSrc)
            RES_ALU: wb_result = alu_out;
            RES_PC1: wb_result = pc_plus1;
            RES_MDR: wb_result = mdr;
            RES_IMM: wb_result = imm_ext;
            default: wb_result = alu_out;
        endcase
    end

    mc_reg_file #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (wb_result),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2),
        .rdata2 (rf_rdata2)
    );

    // Sequencer plus datapath registers; handshake outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            PC         <= '0;
            IR         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            Zero       <= 1'b0;
            instr_req  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            case (state)
                // Accept instr_valid even before the registered request rises.
                S_FETCH: begin
                    if (instr_valid) begin
                        IR        <= instr_rdata;
                        instr_req <= 1'b0;
                        state     <= S_DECODE;
                    end else begin
                        instr_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a_reg <= rf_rdata1;
                    b_reg <= rf_rdata2;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_out <= alu_res;
                    Zero    <= (alu_res == '0);
                    if (ctrl.MemRead || ctrl.MemWrite) begin
                        mem_req <= 1'b1;
                        mem_we  <= ctrl.MemWrite;
                        state   <= S_MEM;
                    end else begin
                        instr_done <= 1'b1;
                        state      <= S_WB;
                    end
                end
                // A write takes priority; read data is only captured for reads.
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            mdr <= mem_rdata;
                        end
                        instr_done <= 1'b1;
                        state      <= S_WB;
                    end
                end
                S_WB: begin
                    PC        <= ctrl.PcSrc ? imm_ext : pc_plus1;
                    instr_req <= 1'b1;
                    state     <= S_FETCH;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

`ifdef MC_DATAPATH_PERF_EN
    // Free-running cycle and retirement counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
